// File: rtl/skl_serial_sub.sv
// Multi-cycle wide subtractor: a - b - bin, one 8-bit Sklansky prefix slice per cycle, LSB first.
// Define SKL_SUB_ADD_MODE_EN to add an 'op' input selecting a + b + bin (op=1) instead.
module skl_serial_sub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
`ifdef SKL_SUB_ADD_MODE_EN
  ,
  input  logic             op
`endif
);

  localparam int NS = WIDTH / 8;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             aMsb_q, aMsb_d, bMsb_q, bMsb_d;
  logic             op_q, op_d;
  logic             opIn;

`ifdef SKL_SUB_ADD_MODE_EN
  assign opIn = op;
`else
  assign opIn = 1'b0;
`endif

  logic [7:0] x, y, sum;
  logic [7:0] gl [4];
  logic [7:0] pl [4];
  logic [8:0] c;
  logic       cout;

  // Low byte of the shift registers goes through an 8-bit Sklansky prefix tree each cycle.
  always_comb begin
    x     = a_q[7:0];
    y     = op_q ? b_q[7:0] : ~b_q[7:0];
    gl[0] = x & y;
    pl[0] = x ^ y;
    for (int k = 0; k < 3; k++) begin
      gl[k+1] = gl[k];
      pl[k+1] = pl[k];
      for (int i = 0; i < 8; i++) begin
        if (((i >> k) & 1) == 1) begin
          gl[k+1][i] = gl[k][i] | (pl[k][i] & gl[k][((i >> k) << k) - 1]);
          pl[k+1][i] = pl[k][i] & pl[k][((i >> k) << k) - 1];
        end
      end
    end
    c[0] = carry_q;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = gl[3][i] | (pl[3][i] & carry_q);
    end
    sum  = pl[0] ^ c[7:0];
    cout = c[8];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    aMsb_d  = aMsb_q;
    bMsb_d  = bMsb_q;
    op_d    = op_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          aMsb_d  = a[WIDTH-1];
          bMsb_d  = b[WIDTH-1];
          op_d    = opIn;
          carry_d = opIn ? bin : ~bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[8*cnt_q +: 8] = sum;
        a_d     = a_q >> 8;
        b_d     = b_q >> 8;
        carry_d = cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NS - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      aMsb_q  <= 1'b0;
      bMsb_q  <= 1'b0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      aMsb_q  <= aMsb_d;
      bMsb_q  <= bMsb_d;
      op_q    <= op_d;
    end
  end

  // In subtract mode the final carry is the inverted borrow.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = out_valid & (op_q ? carry_q : ~carry_q);
  assign overflow  = out_valid & (op_q ? (aMsb_q == bMsb_q) : (aMsb_q != bMsb_q))
                   & (diff_q[WIDTH-1] != aMsb_q);

endmodule
